// File: rtl/len5_pkg.sv
// Shared fetch-path types: instruction word, exception codes and the fetch group bundle.
// Default line geometry lives here so every fetch-side block agrees on it.
package len5_pkg;

  localparam int XLEN       = 64;
  localparam int LINE_INSTR = 16;
  localparam int FETCH_W    = 2;
  localparam int LINE_OFF_W = $clog2(LINE_INSTR) + 2;

  typedef logic [31:0] instr_t;

  typedef enum logic [4:0] {
    E_INSTR_ADDR_MISALIGNED = 5'h00,
    E_INSTR_ACCESS_FAULT    = 5'h01,
    E_ILLEGAL_INSTR         = 5'h02,
    E_BREAKPOINT            = 5'h03,
    E_INSTR_PAGE_FAULT      = 5'h0C,
    E_UNKNOWN               = 5'h1F
  } except_code_t;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    instr_t [FETCH_W-1:0] instr;
    logic [FETCH_W-1:0]   mask;
    logic                 except;
    except_code_t         code;
  } fetch_group_t;

endpackage

// File: rtl/fetch_group_extract.sv
// Selects FETCH_W consecutive instructions starting at idx from a cache line.
// Slots that fall past the end of the line are masked off and zeroed.
module fetch_group_extract
  import len5_pkg::*;
#(
  parameter int LINE_INSTR = len5_pkg::LINE_INSTR,
  parameter int FETCH_W    = len5_pkg::FETCH_W,
  localparam int IDX_W     = $clog2(LINE_INSTR)
) (
  input  logic [LINE_INSTR*32-1:0] line,
  input  logic [IDX_W-1:0]         idx,
  output logic [FETCH_W*32-1:0]    instr,
  output logic [FETCH_W-1:0]       mask
);

  // One extra bit so idx+k never wraps back into the line.
  logic [IDX_W:0] pos;

  always_comb begin
    instr = '0;
    mask  = '0;
    pos   = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      pos     = {1'b0, idx} + (IDX_W+1)'(k);
      mask[k] = (pos < (IDX_W+1)'(LINE_INSTR));
      if (mask[k]) begin
        instr[k*32 +: 32] = line[pos[IDX_W-1:0]*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/fetch_line_buffer.sv
// One-line fetch buffer: accepts an I-cache line (possibly entered mid-line or
// carrying a fetch exception) and hands the decoder aligned FETCH_W-wide groups.
module fetch_line_buffer
  import len5_pkg::*;
#(
  parameter int LINE_INSTR = len5_pkg::LINE_INSTR,
  parameter int FETCH_W    = len5_pkg::FETCH_W,
  parameter int XLEN       = len5_pkg::XLEN
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     line_valid_i,
  output logic                     line_ready_o,
  input  logic [XLEN-1:0]          line_pc_i,
  input  logic [LINE_INSTR*32-1:0] line_i,
  input  logic                     line_except_i,
  input  except_code_t             line_except_code_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          out_pc_o,
  output logic [FETCH_W*32-1:0]    out_instr_o,
  output logic [FETCH_W-1:0]       out_mask_o,
  output logic                     out_except_o,
  output except_code_t             out_except_code_o
);

  localparam int IDX_W = $clog2(LINE_INSTR);
  localparam int OFF_W = IDX_W + 2;

  typedef enum logic [1:0] {S_EMPTY, S_LINE, S_EXCPT} state_t;

  state_t                   state_p0;
  logic [LINE_INSTR*32-1:0] line_p0;
  logic [IDX_W-1:0]         idx_p0;
  logic [XLEN-1:OFF_W]      base_p0;

  logic                     vld_p1;
  logic [XLEN-1:0]          pc_p1;
  logic [FETCH_W*32-1:0]    instr_p1;
  logic [FETCH_W-1:0]       mask_p1;
  logic                     exc_p1;
  except_code_t             code_p1;

  logic [IDX_W:0]           idx_sum;
  logic                     last_grp;
  logic                     fire;
  logic                     accept;
  logic [IDX_W-1:0]         ext_idx;
  logic [LINE_INSTR*32-1:0] ext_line;
  logic [FETCH_W*32-1:0]    ext_instr;
  logic [FETCH_W-1:0]       ext_mask;

  function automatic logic [XLEN-1:0] group_pc(input logic [XLEN-1:OFF_W] base,
                                                input logic [IDX_W-1:0]     idx);
    group_pc = {base, idx, 2'b00};
  endfunction

  assign idx_sum      = {1'b0, idx_p0} + (IDX_W+1)'(FETCH_W);
  assign last_grp     = (state_p0 == S_EXCPT) || (idx_sum >= (IDX_W+1)'(LINE_INSTR));
  assign fire         = vld_p1 & out_ready_i;
  assign line_ready_o = ~flush_i & ((state_p0 == S_EMPTY) | (fire & last_grp));
  assign accept       = line_valid_i & line_ready_o;

  // The extractor looks at the group that becomes visible next cycle, so the
  // outputs can be registered without a combinational input-to-output path.
  assign ext_idx  = accept ? line_pc_i[OFF_W-1:2] : idx_sum[IDX_W-1:0];
  assign ext_line = accept ? line_i : line_p0;

  fetch_group_extract #(
    .LINE_INSTR (LINE_INSTR),
    .FETCH_W    (FETCH_W)
  ) u_extract (
    .line  (ext_line),
    .idx   (ext_idx),
    .instr (ext_instr),
    .mask  (ext_mask)
  );

  // Stage p0 -> p1: line state and registered output group
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p0 <= S_EMPTY;
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      instr_p1 <= '0;
      mask_p1  <= '0;
      exc_p1   <= 1'b0;
      code_p1  <= except_code_t'(5'h00);
    end else if (flush_i) begin
      state_p0 <= S_EMPTY;
      vld_p1   <= 1'b0;
      mask_p1  <= '0;
      exc_p1   <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      if (line_except_i) begin
        state_p0 <= S_EXCPT;
        pc_p1    <= line_pc_i;
        instr_p1 <= '0;
        mask_p1  <= FETCH_W'(1);
        exc_p1   <= 1'b1;
        code_p1  <= line_except_code_i;
      end else begin
        state_p0 <= S_LINE;
        idx_p0   <= line_pc_i[OFF_W-1:2];
        base_p0  <= line_pc_i[XLEN-1:OFF_W];
        line_p0  <= line_i;
        pc_p1    <= group_pc(line_pc_i[XLEN-1:OFF_W], line_pc_i[OFF_W-1:2]);
        instr_p1 <= ext_instr;
        mask_p1  <= ext_mask;
        exc_p1   <= 1'b0;
        code_p1  <= except_code_t'(5'h00);
      end
    end else if (fire) begin
      if (last_grp) begin
        state_p0 <= S_EMPTY;
        vld_p1   <= 1'b0;
        mask_p1  <= '0;
        exc_p1   <= 1'b0;
      end else begin
        idx_p0   <= idx_sum[IDX_W-1:0];
        pc_p1    <= group_pc(base_p0, idx_sum[IDX_W-1:0]);
        instr_p1 <= ext_instr;
        mask_p1  <= ext_mask;
      end
    end
  end

  assign out_valid_o       = vld_p1;
  assign out_pc_o          = pc_p1;
  assign out_instr_o       = instr_p1;
  assign out_mask_o        = mask_p1;
  assign out_except_o      = exc_p1;
  assign out_except_code_o = code_p1;

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Directed bench for fetch_line_buffer: a queue-of-beats model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_fetch_line_buffer;
  import len5_pkg::*;

  localparam int LI = 16;
  localparam int FW = 2;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          lvalid;
  logic          lready;
  logic [63:0]   lpc;
  logic [511:0]  lline;
  logic          lexc;
  except_code_t  lcode;
  logic          ovalid;
  logic          oready;
  logic [63:0]   opc;
  logic [63:0]   oinstr;
  logic [1:0]    omask;
  logic          oexc;
  except_code_t  ocode;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] instr;
    logic [1:0]  mask;
    logic        exc;
    logic [4:0]  code;
  } beat_t;

  beat_t q[$];

  fetch_line_buffer dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_i            (flush),
    .line_valid_i       (lvalid),
    .line_ready_o       (lready),
    .line_pc_i          (lpc),
    .line_i             (lline),
    .line_except_i      (lexc),
    .line_except_code_i (lcode),
    .out_valid_o        (ovalid),
    .out_ready_i        (oready),
    .out_pc_o           (opc),
    .out_instr_o        (oinstr),
    .out_mask_o         (omask),
    .out_except_o       (oexc),
    .out_except_code_o  (ocode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [511:0] mk_line(input int tag);
    logic [511:0] l;
    for (int i = 0; i < LI; i++) l[i*32 +: 32] = 32'hA000_0000 + 32'(tag * 256 + i);
    return l;
  endfunction

  // Expand an accepted line into the sequence of groups the decoder must see.
  task automatic model_accept(input logic [63:0] pc, input logic [511:0] ln,
                              input logic exc, input logic [4:0] code);
    beat_t b;
    if (exc) begin
      b.pc = pc; b.instr = '0; b.mask = 2'b01; b.exc = 1'b1; b.code = code;
      q.push_back(b);
    end else begin
      for (int i = int'(pc[5:2]); i < LI; i += FW) begin
        b.pc = {pc[63:6], 6'b0} + 64'(i * 4);
        b.instr = '0; b.mask = '0; b.exc = 1'b0; b.code = '0;
        for (int k = 0; k < FW; k++) begin
          if (i + k < LI) begin
            b.mask[k] = 1'b1;
            b.instr[k*32 +: 32] = ln[(i+k)*32 +: 32];
          end
        end
        q.push_back(b);
      end
    end
  endtask

  // Per-cycle compare against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    logic exp_rdy;
    logic fire_m;
    beat_t h;
    exp_rdy = !flush && (q.size() == 0 || (q.size() == 1 && oready));
    check("line_ready", 64'(lready), 64'(exp_rdy));
    if (q.size() == 0) begin
      check("idle_valid", 64'(ovalid), 64'd0);
    end else begin
      h = q[0];
      check("valid", 64'(ovalid), 64'd1);
      check("pc", opc, h.pc);
      check("mask", 64'(omask), 64'(h.mask));
      check("except", 64'(oexc), 64'(h.exc));
      if (h.exc) check("code", 64'(ocode), 64'(h.code));
      for (int k = 0; k < FW; k++)
        if (h.mask[k] || h.exc) check("instr_slot", 64'(oinstr[k*32 +: 32]), 64'(h.instr[k*32 +: 32]));
    end
    if (rst || flush) begin
      q.delete();
    end else begin
      fire_m = (q.size() > 0) && oready;
      if (fire_m) void'(q.pop_front());
      if (lvalid && exp_rdy) model_accept(lpc, lline, lexc, lcode);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && ovalid; n++) tick();
    check("drain_done", 64'(ovalid), 64'd0);
  endtask

  task automatic present(input logic [63:0] pc, input int tag);
    lvalid = 1'b1; lpc = pc; lline = mk_line(tag); lexc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; lvalid = 1'b0; lpc = '0; lline = '0;
    lexc = 1'b0; lcode = E_INSTR_ADDR_MISALIGNED; oready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", 64'(ovalid), 64'd0);
    check("rst_pc", opc, 64'd0);
    check("rst_instr", oinstr, 64'd0);
    check("rst_mask", 64'(omask), 64'd0);
    check("rst_except", 64'(oexc), 64'd0);
    check("rst_code", 64'(ocode), 64'd0);
    check("rst_ready", 64'(lready), 64'd1);

    // Aligned line: 8 groups
    present(64'h1000, 1);
    tick();
    lvalid = 1'b0;
    check("al_pc0", opc, 64'h1000);
    check("al_mask0", 64'(omask), 64'h3);
    check("al_instr0", oinstr, 64'hA000_0101_A000_0100);
    for (int i = 0; i < 7; i++) tick();
    check("al_pc7", opc, 64'h1038);
    check("al_ready7", 64'(lready), 64'd1);
    drain();

    // Unaligned entry at instruction 13
    present(64'h1034, 2);
    tick();
    lvalid = 1'b0;
    check("un_pc0", opc, 64'h1034);
    check("un_mask0", 64'(omask), 64'h3);
    check("un_instr0", oinstr, 64'hA000_020E_A000_020D);
    tick();
    check("un_pc1", opc, 64'h103C);
    check("un_mask1", 64'(omask), 64'h1);
    check("un_instr1", 64'(oinstr[31:0]), 64'hA000_020F);
    tick();
    check("un_empty", 64'(ovalid), 64'd0);

    // Backpressure at 0x1010
    present(64'h1000, 3);
    tick();
    lvalid = 1'b0;
    tick(); tick();
    oready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_pc", opc, 64'h1010);
      check("bp_instr", oinstr, 64'hA000_0305_A000_0304);
    end
    oready = 1'b1;
    tick();
    check("bp_release_pc", opc, 64'h1018);
    drain();

    // Exception line
    lvalid = 1'b1; lpc = 64'h2008; lline = mk_line(9); lexc = 1'b1; lcode = E_INSTR_PAGE_FAULT;
    tick();
    lvalid = 1'b0; lexc = 1'b0; lcode = E_INSTR_ADDR_MISALIGNED;
    check("ex_valid", 64'(ovalid), 64'd1);
    check("ex_pc", opc, 64'h2008);
    check("ex_mask", 64'(omask), 64'h1);
    check("ex_flag", 64'(oexc), 64'd1);
    check("ex_code", 64'(ocode), 64'h0C);
    check("ex_instr", oinstr, 64'd0);
    tick();
    check("ex_empty", 64'(ovalid), 64'd0);

    // Flush at idx 4 with a new line presented in the same cycle
    present(64'h1000, 4);
    tick();
    lvalid = 1'b0;
    tick(); tick();
    check("fl_pc_idx4", opc, 64'h1010);
    flush = 1'b1;
    present(64'h1040, 5);
    tick();
    check("fl_valid", 64'(ovalid), 64'd0);
    flush = 1'b0;
    tick();
    lvalid = 1'b0;
    check("fl_reaccept_pc", opc, 64'h1040);
    check("fl_reaccept_instr", oinstr, 64'hA000_0501_A000_0500);
    drain();

    // Back-to-back lines, then reset mid-line
    present(64'h1000, 6);
    tick();
    present(64'h1040, 7);
    for (int i = 1; i < 19; i++) begin
      tick();
      check("b2b_valid", 64'(ovalid), 64'd1);
      if (i == 8) begin
        check("b2b_pc_second", opc, 64'h1040);
        present(64'h1080, 8);
      end
      if (i == 16) begin
        check("b2b_pc_third", opc, 64'h1080);
        lvalid = 1'b0;
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", 64'(ovalid), 64'd0);
    check("rst_mid_pc", opc, 64'd0);
    tick();
    check("rst_mid_idle", 64'(ovalid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
